// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge: FSM state encoding,
// default bus widths and response codes.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    localparam logic APB_RESP_OK  = 1'b0;
    localparam logic APB_RESP_ERR = 1'b1;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundle of the request/response stream and the APB3 bus seen by the bridge.
// master = bridge side, slave = command source plus APB slave side.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
               pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
               pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter with terminal-count flag; only instantiated when
// APB_MASTER_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic pclk,
    input  logic prst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request stream to APB3 master, one transfer in flight.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic                pclk,
    input  logic                prst,
    apb_master_bridge_if.master bus
);

    apb_state_e        r_state,       w_state_next;
    logic              r_req_ready,   w_req_ready_next;
    logic              r_rsp_valid,   w_rsp_valid_next;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_next;
    logic              r_rsp_err,     w_rsp_err_next;
    logic              r_psel,        w_psel_next;
    logic              r_penable,     w_penable_next;
    logic              r_pwrite,      w_pwrite_next;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_next;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_next;
    logic              w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_timer_clear;
    logic w_timer_inc;

    // SETUP always precedes ACCESS, so clearing there restarts the count on entry.
    assign w_timer_clear = (r_state == SETUP);
    assign w_timer_inc   = (r_state == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (8)
    ) u_wait_timer (
        .pclk      (pclk),
        .prst      (prst),
        .i_clear   (w_timer_clear),
        .i_inc     (w_timer_inc),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= APB_RESP_OK;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_req_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_pwrite    <= w_pwrite_next;
            r_paddr     <= w_paddr_next;
            r_pwdata    <= w_pwdata_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_req_ready_next = r_req_ready;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_err_next   = r_rsp_err;
        w_psel_next      = r_psel;
        w_penable_next   = r_penable;
        w_pwrite_next    = r_pwrite;
        w_paddr_next     = r_paddr;
        w_pwdata_next    = r_pwdata;

        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_pwrite_next    = bus.req_write;
                    w_paddr_next     = bus.req_addr;
                    w_pwdata_next    = bus.req_wdata;
                    w_psel_next      = 1'b1;
                    w_penable_next   = 1'b0;
                    w_req_ready_next = 1'b0;
                    w_state_next     = SETUP;
                end
            end
            SETUP: begin
                w_penable_next = 1'b1;
                w_state_next   = ACCESS;
            end
            ACCESS: begin
                // A late pready in the terminal cycle still completes normally.
                if (bus.pready) begin
                    w_rsp_rdata_next = r_pwrite ? '0 : bus.prdata;
                    w_rsp_err_next   = bus.pslverr ? APB_RESP_ERR : APB_RESP_OK;
                    w_psel_next      = 1'b0;
                    w_penable_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = RESP;
                end else if (w_timeout) begin
                    w_rsp_rdata_next = '0;
                    w_rsp_err_next   = APB_RESP_ERR;
                    w_psel_next      = 1'b0;
                    w_penable_next   = 1'b0;
                    w_rsp_valid_next = 1'b1;
                    w_state_next     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
                    w_req_ready_next = 1'b1;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers against a memory-backed APB slave model.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;

    logic pclk = 1'b0;
    logic prst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [DW-1:0] mem [256];

    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus_if.master)
    );

    // One complete transfer; starts and ends just after a falling edge.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input logic err, input int delay, input logic hold_req);
        logic [DW-1:0] exp_rdata;
        int n_psel;
        int n_pen;
        exp_rdata = wr ? '0 : mem[a];
        n_psel = 0;
        n_pen  = 0;
        $display("xfer %s addr=%h wdata=%h waits=%0d err=%0b rsp_delay=%0d",
                 wr ? "WR" : "RD", a, d, waits, err, delay);

        n_total++;
        if (bus_if.req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b expected 1", bus_if.req_ready);
        else n_pass++;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = wr;
        bus_if.req_addr  = a;
        bus_if.req_wdata = d;

        @(negedge pclk);
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'($urandom);
        bus_if.req_addr  = AW'($urandom);
        bus_if.req_wdata = DW'($urandom);
        n_psel += int'(bus_if.psel);
        n_pen  += int'(bus_if.penable);
        n_total++;
        if ({bus_if.psel, bus_if.penable, bus_if.req_ready, bus_if.rsp_valid} !== 4'b1000)
            $display("FAIL setup_ctrl: got %b expected 1000",
                     {bus_if.psel, bus_if.penable, bus_if.req_ready, bus_if.rsp_valid});
        else n_pass++;
        n_total++;
        if ({bus_if.pwrite, bus_if.paddr, bus_if.pwdata} !== {wr, a, d})
            $display("FAIL setup_addr: got %h expected %h", {bus_if.pwrite, bus_if.paddr, bus_if.pwdata}, {wr, a, d});
        else n_pass++;
        bus_if.pready  = 1'($urandom);
        bus_if.pslverr = 1'($urandom);
        bus_if.prdata  = DW'($urandom);

        for (int i = 0; i <= waits; i++) begin
            @(negedge pclk);
            n_psel += int'(bus_if.psel);
            n_pen  += int'(bus_if.penable);
            n_total++;
            if ({bus_if.psel, bus_if.penable, bus_if.rsp_valid} !== 3'b110)
                $display("FAIL access_ctrl: got %b expected 110 (cycle %0d)",
                         {bus_if.psel, bus_if.penable, bus_if.rsp_valid}, i);
            else n_pass++;
            n_total++;
            if ({bus_if.pwrite, bus_if.paddr, bus_if.pwdata} !== {wr, a, d})
                $display("FAIL access_addr: got %h expected %h", {bus_if.pwrite, bus_if.paddr, bus_if.pwdata}, {wr, a, d});
            else n_pass++;
            if (i == waits) begin
                bus_if.pready  = 1'b1;
                bus_if.pslverr = err;
                bus_if.prdata  = wr ? DW'($urandom) : mem[a];
            end else begin
                bus_if.pready  = 1'b0;
                bus_if.pslverr = 1'($urandom);
                bus_if.prdata  = DW'($urandom);
            end
        end

        @(negedge pclk);
        bus_if.pready  = 1'b0;
        bus_if.pslverr = 1'b0;
        if (wr && !err) mem[a] = d;

        for (int k = 0; k <= delay; k++) begin
            n_psel += int'(bus_if.psel);
            n_pen  += int'(bus_if.penable);
            n_total++;
            if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.req_ready} !== {1'b1, err, 3'b000})
                $display("FAIL resp_ctrl: got %b expected %b",
                         {bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.req_ready}, {1'b1, err, 3'b000});
            else n_pass++;
            n_total++;
            if (bus_if.rsp_rdata !== exp_rdata)
                $display("FAIL resp_rdata: got %h expected %h", bus_if.rsp_rdata, exp_rdata);
            else n_pass++;
            n_total++;
            if ({bus_if.pwrite, bus_if.paddr, bus_if.pwdata} !== {wr, a, d})
                $display("FAIL resp_addr_hold: got %h expected %h", {bus_if.pwrite, bus_if.paddr, bus_if.pwdata}, {wr, a, d});
            else n_pass++;
            bus_if.rsp_ready = (k == delay);
            if (hold_req) begin
                bus_if.req_valid = 1'b1;
                bus_if.req_write = 1'($urandom);
                bus_if.req_addr  = AW'($urandom);
            end
            @(negedge pclk);
        end
        bus_if.rsp_ready = 1'b0;
        bus_if.req_valid = 1'b0;

        n_total++;
        if ({bus_if.rsp_valid, bus_if.req_ready, bus_if.psel} !== 3'b010)
            $display("FAIL post_handshake: got %b expected 010", {bus_if.rsp_valid, bus_if.req_ready, bus_if.psel});
        else n_pass++;
        n_total++;
        if (n_psel != waits + 2 || n_pen != waits + 1)
            $display("FAIL psel_penable_cycles: got %0d/%0d expected %0d/%0d", n_psel, n_pen, waits + 2, waits + 1);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge pclk);
        n_total++;
        if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.pwrite} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.pwrite});
        else n_pass++;
        n_total++;
        if ({bus_if.paddr, bus_if.pwdata, bus_if.rsp_rdata} !== 72'h0)
            $display("FAIL reset_data: got %h expected 0", {bus_if.paddr, bus_if.pwdata, bus_if.rsp_rdata});
        else n_pass++;
        prst = 1'b1;
        @(negedge pclk);
        n_total++;
        if ({bus_if.req_ready, bus_if.psel, bus_if.rsp_valid} !== 3'b100)
            $display("FAIL reset_release: got %b expected 100", {bus_if.req_ready, bus_if.psel, bus_if.rsp_valid});
        else n_pass++;
    endtask

    task automatic test_write_zero_wait;
        do_xfer(1'b1, 8'h04, 32'hDEADBEEF, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_wait3;
        do_xfer(1'b0, 8'h04, 32'h0, 3, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slave_error;
        do_xfer(1'b0, 8'h1F, 32'h0, 0, 1'b1, 0, 1'b0);
        do_xfer(1'b1, 8'h1F, 32'h12345678, 0, 1'b1, 1, 1'b0);
        do_xfer(1'b1, 8'h1F, 32'hCAFEF00D, 1, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 8'h1F, 32'h0, 2, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_xfer(1'b0, 8'h04, 32'h0, 1, 1'b0, 4, 1'b1);
    endtask

    task automatic test_random;
        for (int t = 0; t < 24; t++) begin
            do_xfer(1'($urandom), AW'($urandom_range(15)), DW'($urandom), int'($urandom_range(4)),
                    1'($urandom_range(7) == 0), int'($urandom_range(3)), 1'($urandom));
        end
    endtask

    task automatic test_long_access;
`ifdef APB_MASTER_TIMEOUT_EN
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = 8'h08;
        @(negedge pclk);
        bus_if.req_valid = 1'b0;
        bus_if.pready    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            n_total++;
            if ({bus_if.psel, bus_if.penable, bus_if.rsp_valid} !== 3'b110)
                $display("FAIL timeout_access: got %b expected 110 (cycle %0d)", {bus_if.psel, bus_if.penable, bus_if.rsp_valid}, i);
            else n_pass++;
        end
        @(negedge pclk);
        n_total++;
        if ({bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.rsp_rdata} !== {4'b1100, 32'h0})
            $display("FAIL timeout_abort: got %h expected %h",
                     {bus_if.rsp_valid, bus_if.rsp_err, bus_if.psel, bus_if.penable, bus_if.rsp_rdata}, {4'b1100, 32'h0});
        else n_pass++;
        bus_if.rsp_ready = 1'b1;
        @(negedge pclk);
        bus_if.rsp_ready = 1'b0;
        do_xfer(1'b0, 8'h08, 32'h0, 15, 1'b0, 0, 1'b0);
`else
        do_xfer(1'b0, 8'h08, 32'h0, 20, 1'b0, 0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_access;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = 1'b1;
        bus_if.req_addr  = 8'h10;
        bus_if.req_wdata = 32'hA5A5_5A5A;
        @(negedge pclk);
        bus_if.req_valid = 1'b0;
        bus_if.pready    = 1'b0;
        @(negedge pclk);
        n_total++;
        if (bus_if.penable !== 1'b1) $display("FAIL mid_access_penable: got %b expected 1", bus_if.penable);
        else n_pass++;
        #2 prst = 1'b0;
        #1;
        n_total++;
        if ({bus_if.psel, bus_if.penable, bus_if.rsp_valid, bus_if.req_ready} !== 4'b0001)
            $display("FAIL async_reset_ctrl: got %b expected 0001", {bus_if.psel, bus_if.penable, bus_if.rsp_valid, bus_if.req_ready});
        else n_pass++;
        n_total++;
        if ({bus_if.pwrite, bus_if.paddr, bus_if.pwdata, bus_if.rsp_rdata, bus_if.rsp_err} !== 74'h0)
            $display("FAIL async_reset_data: got %h expected 0",
                     {bus_if.pwrite, bus_if.paddr, bus_if.pwdata, bus_if.rsp_rdata, bus_if.rsp_err});
        else n_pass++;
        @(negedge pclk);
        prst = 1'b1;
        bus_if.pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n_total++;
            if ({bus_if.rsp_valid, bus_if.psel, bus_if.req_ready} !== 3'b001)
                $display("FAIL post_reset_idle: got %b expected 001", {bus_if.rsp_valid, bus_if.psel, bus_if.req_ready});
            else n_pass++;
        end
        bus_if.pready = 1'b0;
        do_xfer(1'b0, 8'h10, 32'h0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.pready    = 1'b0;
        bus_if.pslverr   = 1'b0;
        bus_if.prdata    = '0;

        test_reset;
        test_write_zero_wait;
        test_read_wait3;
        test_slave_error;
        test_backpressure;
        test_random;
        test_long_access;
        test_reset_mid_access;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the team's APB memory slave: converts a simple valid/ready request stream into APB3 transfers.
- Drives psel/penable/pwrite/paddr/pwdata, waits for pready, and returns prdata/pslverr on a valid/ready response channel.
- Single outstanding transfer; sits between the local command source (CPU shim or test sequencer) and the APB slave.

Parameters:
- ADDR_W, 8, width of req_addr/paddr.
- DATA_W, 32, width of all data buses.
- TIMEOUT_CYC, 16, ACCESS-phase cycles before abort (used only with the optional feature).

Ports:
- pclk  in  1  clock, all logic on rising edge.
- prst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by upstream.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error, sampled only with pready.
- prdata  in  DATA_W  slave read data, sampled only with pready.

Behaviour:
- All outputs are registered. Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge N: latch write/addr/wdata into pwrite/paddr/pwdata, set psel=1, penable=0, req_ready=0, go SETUP.
  - psel is visible in cycle N+1.
- SETUP: unconditionally set penable=1 and go ACCESS. pready is ignored in SETUP.
- ACCESS: psel=1, penable=1; paddr, pwrite and pwdata are held stable. At the first edge with pready=1:
  - capture rsp_rdata (prdata for reads, 0 for writes) and rsp_err=pslverr;
  - clear psel and penable;
  - set rsp_valid=1 and go RESP.
- RESP:
  - Hold rsp_valid, rsp_rdata and rsp_err until rsp_ready=1.
  - On that edge: rsp_valid=0, req_ready=1, go IDLE.
  - rsp_ready=1 in the same cycle rsp_valid first rises completes the handshake at the next edge.
- Minimum occupancy is 4 cycles per transfer (IDLE accept, SETUP, ACCESS with zero wait, RESP). There is no back-to-back SETUP; psel always drops for at least 2 cycles between transfers.
- paddr, pwrite and pwdata keep their last values in IDLE and RESP (no toggling).
- req_valid with req_ready=0 is ignored. The requester must hold the request until accepted.
- Reset mid-transfer (any state): outputs return to reset values immediately and asynchronously. The in-flight request is dropped and no response is issued.
- pslverr without pready is ignored.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When the count reaches TIMEOUT_CYC-1 with pready still 0, the bridge aborts: psel=0, penable=0, rsp_rdata=0, rsp_err=1, go RESP.
  - If pready arrives in that same cycle, pready wins (normal completion).
- Not defined: no counter logic exists and ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11);
  - default ADDR_W and DATA_W constants;
  - APB_RESP_OK/APB_RESP_ERR constants.
- One sub-module, apb_wait_timer: counter plus terminal-count compare, instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write, zero wait: req addr=0x04, wdata=0xDEADBEEF; slave pready=1 in first ACCESS cycle -> psel high 2 cycles, penable 1 cycle; rsp_valid with rsp_err=0, rsp_rdata=0; req_ready back after rsp_ready.
- Read with 3 wait states: addr=0x04, slave returns 0xDEADBEEF after 3 low-pready ACCESS cycles -> paddr stable for 5 cycles; rsp_rdata=0xDEADBEEF.
- Slave error: read addr=0x1F, pready=1 with pslverr=1 -> rsp_err=1; next request still accepted normally.
- Response backpressure: rsp_ready low for 4 cycles -> rsp_valid and data held; req_valid asserted meanwhile is not accepted (req_ready=0).
- Reset mid-ACCESS: drive prst=0 while penable=1 -> psel, penable and rsp_valid go to 0 without a clock edge; after release, req_ready=1 and no stale response appears.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=16, pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0. Same case with pready=1 on cycle 16 -> normal completion, rsp_err=0.
